uart_rx_monitor: RTL and testbench
==================================

# uart_rx_monitor

Parametrised multi-channel UART receive monitor for the e203 SoC demo. It decodes one or more idle-high serial lines (8 data bits, optional parity, 1 stop bit) and buffers each received byte with error flags in a per-channel FIFO. A round-robin valid/ready port delivers the bytes to the bench or to on-chip capture logic. It supersedes the single-channel fixed-baud console capture: channel count, baud divisor, FIFO depth and parity mode are now parameters, and it adds error and overflow reporting.

## Interface
- NUM_CH, 1: number of independent rx lines (1..8).
- CLKS_PER_BIT, 234: clk cycles per bit; 234 gives 115200 baud at 27 MHz; minimum 4.
- FIFO_DEPTH, 4: entries per channel FIFO; power of two, ≥2.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous assert, active-high.
- rx  in  NUM_CH  serial lines, idle high, asynchronous to clk.
- out_valid  out  1  byte available.
- out_ready  in  1  consumer accepts the byte.
- out_ch  out  $clog2(NUM_CH) (min 1)  source channel.
- out_data  out  8  received byte.
- out_ferr  out  1  stop bit sampled low.
- out_perr  out  1  parity mismatch; always 0 when PARITY=0.
- ovf  out  NUM_CH  sticky per-channel overflow.

## Operation
- Each rx bit passes through a 2-flop synchroniser. The reset value of both flops is 1.
- Per-channel FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE → START: on a synchronised falling edge. Load the bit counter with CLKS_PER_BIT/2 − 1.
- START: when the counter expires, sample the line.
  - Line low: go to DATA and reload the counter with CLKS_PER_BIT − 1.
  - Line high: false start; return to IDLE and push nothing.
- DATA: sample 8 bits, one per counter expiry, LSB first.
  - After the 8th sample, go to PAR if PARITY≠0, otherwise go to STOP.
- PAR: sample the parity bit. perr = (XOR of data bits and parity bit) ≠ (PARITY==2).
- STOP: sample the stop bit. ferr = !sample.
  - Push {perr, ferr, data} into the channel FIFO.
  - Go straight to IDLE, so a start edge immediately after the stop sample is accepted.
- Bytes with errors are still pushed.
- FIFO full at push time: drop the byte and set ovf[ch]. ovf clears only on reset.
- Output register:
  - When out_valid=0, or out_valid&out_ready, load the next entry from the round-robin arbiter.
  - The arbiter searches from the channel after the last granted one.
  - If no FIFO is non-empty, out_valid goes to 0.
- While out_valid=1 and out_ready=0, out_ch/out_data/out_ferr/out_perr are held stable.
- Simultaneous push and pop on one FIFO: both occur. A full FIFO that is popped in the same cycle accepts the push without overflow.

## Timing
- Reset values: out_valid=0, out_ch=0, out_data=0, out_ferr=0, out_perr=0, ovf=0. All FSMs are in IDLE, FIFOs are empty and the arbiter pointer is 0.
- Reset asserted mid-frame: the partial frame is discarded. After release, the FSM waits for a fresh falling edge.
- Each bit is sampled at its centre, CLKS_PER_BIT/2 after the synchronised start edge and every CLKS_PER_BIT thereafter.
- Latency from synchronised start edge to FIFO push: (CLKS_PER_BIT/2 − 1) + (9 + P)·CLKS_PER_BIT + 1 cycles, where P = 1 if PARITY≠0, else 0.
- Push to out_valid: 1 cycle when the output register is free.
- Throughput: 1 byte/cycle, back to back, when out_ready is held high.

## Structure
- Package uart_mon_pkg:
  - rx_state_e enum (IDLE, START, DATA, PAR, STOP).
  - parity_e constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2).
  - rx_entry_t packed struct {perr, ferr, data[7:0]}.
- Sub-module uart_rx_chan: synchroniser, bit counter, FSM and FIFO for one channel; instantiated NUM_CH times in a generate loop.
- The top level holds the round-robin arbiter and the output register.

## Test plan
- NUM_CH=1, CLKS_PER_BIT=8, PARITY=0: drive 0x55 then 0xA3 → two outputs with out_data=0x55 then 0xA3, ferr=perr=0, ovf=0.
- PARITY=1: send 0x07 with parity bit 1 (correct) → perr=0. Send 0x07 with parity bit 0 → perr=1, data=0x07.
- Stop bit driven low on 0x3C → out_data=0x3C, ferr=1. A 2-cycle low glitch on rx → no output.
- FIFO_DEPTH=4, out_ready=0, send 5 bytes → out register plus 4 FIFO entries accept all 5. A 6th byte is dropped and ovf[0]=1. Drain yields the first 5 in order.
- NUM_CH=3: all channels receive simultaneously (0x11, 0x22, 0x33), out_ready=1 → out_ch order 0, 1, 2 on consecutive cycles.
- Assert rst during DATA of channel 0 → out_valid=0 and ovf=0. A subsequent full 0x9E frame is received correctly.

Source files
------------

// File: rtl/uart_mon_pkg.sv
// Shared types and helpers for the multi-channel UART receive monitor.
// Holds the receiver state encoding, the parity-mode constants and the
// layout of one buffered byte with its error flags.

package uart_mon_pkg;

    // Per-channel receiver states, one per part of the serial frame.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_e;

    // Parity modes selected by the PARITY parameter.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    // One received byte together with its error flags, as stored in a FIFO.
    typedef struct packed {
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } rx_entry_t;

    // Parity error: the XOR over the data bits and the received parity bit
    // is 0 for a good even-parity frame and 1 for a good odd-parity frame.
    function automatic logic calcPerr(input logic [7:0] dataBits,
                                      input logic       parBit,
                                      input int         mode);
        logic onesOdd;
        logic wantOdd;
        onesOdd = (^dataBits) ^ parBit;
        wantOdd = (mode == int'(PAR_ODD));
        return (onesOdd != wantOdd);
    endfunction

endpackage

// File: rtl/uart_rx_chan.sv
// One receive channel of the UART monitor: input synchroniser, bit-timing
// counter, frame FSM and a small FIFO of received bytes with error flags.
// The FIFO drops bytes that arrive while it is full and latches an overflow.

module uart_rx_chan
    import uart_mon_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY       = 0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx_i,
    input  logic      pop_i,
    output logic      notEmpty_o,
    output rx_entry_t head_o,
    output logic      ovf_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    // Synchroniser and edge-detect flops, all idle-high out of reset.
    logic syncMeta_q;
    logic syncLine_q;
    logic linePrev_q;
    logic fallEdge;

    // Frame FSM state.
    rx_state_e        state_q;
    logic [CNT_W-1:0] tickCnt_q;
    logic [2:0]       bitIdx_q;
    logic [7:0]       shift_q;
    logic             perr_q;
    logic             pushValid_q;
    rx_entry_t        pushEntry_q;

    // FIFO storage and pointers; the extra pointer bit tells full from empty.
    rx_entry_t        mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wrPtr_q;
    logic [PTR_W:0]   rdPtr_q;
    logic             ovf_q;
    logic             fifoEmpty;
    logic             fifoFull;
    logic             doPop;
    logic             doPush;
    logic             doDrop;

    // Bring the asynchronous line into the clock domain and keep one more
    // delayed copy so a falling edge can be seen on settled values only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncMeta_q <= 1'b1;
            syncLine_q <= 1'b1;
            linePrev_q <= 1'b1;
        end else begin
            syncMeta_q <= rx_i;
            syncLine_q <= syncMeta_q;
            linePrev_q <= syncLine_q;
        end
    end

    assign fallEdge = linePrev_q & ~syncLine_q;

    // Frame FSM: half a bit to reach the start-bit centre, then one sample
    // per bit period; the finished byte is handed to the FIFO one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tickCnt_q   <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            perr_q      <= 1'b0;
            pushValid_q <= 1'b0;
            pushEntry_q <= '0;
        end else begin
            pushValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fallEdge) begin
                        tickCnt_q <= HALF_LOAD;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (tickCnt_q == '0) begin
                        if (!syncLine_q) begin
                            tickCnt_q <= FULL_LOAD;
                            bitIdx_q  <= '0;
                            perr_q    <= 1'b0;
                            state_q   <= DATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        tickCnt_q <= tickCnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (tickCnt_q == '0) begin
                        shift_q   <= {syncLine_q, shift_q[7:1]};
                        tickCnt_q <= FULL_LOAD;
                        bitIdx_q  <= bitIdx_q + 1'b1;
                        if (bitIdx_q == 3'd7) begin
                            if (PARITY != int'(PAR_NONE)) begin
                                state_q <= PAR;
                            end else begin
                                state_q <= STOP;
                            end
                        end
                    end else begin
                        tickCnt_q <= tickCnt_q - 1'b1;
                    end
                end
                PAR: begin
                    if (tickCnt_q == '0) begin
                        perr_q    <= calcPerr(shift_q, syncLine_q, PARITY);
                        tickCnt_q <= FULL_LOAD;
                        state_q   <= STOP;
                    end else begin
                        tickCnt_q <= tickCnt_q - 1'b1;
                    end
                end
                STOP: begin
                    if (tickCnt_q == '0) begin
                        pushValid_q      <= 1'b1;
                        pushEntry_q.perr <= perr_q;
                        pushEntry_q.ferr <= ~syncLine_q;
                        pushEntry_q.data <= shift_q;
                        state_q          <= IDLE;
                    end else begin
                        tickCnt_q <= tickCnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                       (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign doPop     = pop_i & ~fifoEmpty;
    assign doPush    = pushValid_q & (~fifoFull | doPop);
    assign doDrop    = pushValid_q & fifoFull & ~doPop;

    // FIFO payload storage; contents need no reset because the pointers
    // decide what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[PTR_W-1:0]] <= pushEntry_q;
        end
    end

    // FIFO pointers and the sticky overflow flag; a pop in the same cycle
    // frees the slot so a push into a full FIFO still succeeds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doDrop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign notEmpty_o = ~fifoEmpty;
    assign head_o     = mem_q[rdPtr_q[PTR_W-1:0]];
    assign ovf_o      = ovf_q;

endmodule

// File: rtl/uart_rx_monitor.sv
// Multi-channel UART receive monitor: NUM_CH independent receive channels
// feed a round-robin arbiter and a single registered valid/ready output.

module uart_rx_monitor
    import uart_mon_pkg::*;
#(
    parameter int NUM_CH       = 1,
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY       = 0,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] rx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [7:0]        out_data,
    output logic              out_ferr,
    output logic              out_perr,
    output logic [NUM_CH-1:0] ovf
);

    logic [NUM_CH-1:0] chNotEmpty;
    logic [NUM_CH-1:0] chPop;
    logic [NUM_CH-1:0] chOvf;
    rx_entry_t         chHead [NUM_CH];

    logic              loadSlot;
    logic              grantValid;
    logic [CH_W-1:0]   grantCh;
    rx_entry_t         grantEntry;
    logic [CH_W-1:0]   nextPtr;

    logic              outValid_q;
    logic [CH_W-1:0]   outCh_q;
    logic [7:0]        outData_q;
    logic              outFerr_q;
    logic              outPerr_q;
    logic [CH_W-1:0]   rrPtr_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : gChan
        uart_rx_chan #(
            .CLKS_PER_BIT (CLKS_PER_BIT),
            .FIFO_DEPTH   (FIFO_DEPTH),
            .PARITY       (PARITY)
        ) uChan (
            .clk        (clk),
            .rst        (rst),
            .rx_i       (rx[g]),
            .pop_i      (chPop[g]),
            .notEmpty_o (chNotEmpty[g]),
            .head_o     (chHead[g]),
            .ovf_o      (chOvf[g])
        );
    end

    assign ovf      = chOvf;
    assign loadSlot = ~outValid_q | out_ready;

    // Round-robin search starting at rrPtr_q; walking the order backwards
    // lets the first non-empty channel in search order win the last write.
    always_comb begin
        int idx;
        logic [CH_W-1:0] candCh;
        idx        = 0;
        candCh     = '0;
        grantValid = 1'b0;
        grantCh    = '0;
        grantEntry = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(rrPtr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            candCh = CH_W'(idx);
            if (chNotEmpty[candCh]) begin
                grantValid = 1'b1;
                grantCh    = candCh;
                grantEntry = chHead[candCh];
            end
        end
    end

    // Pop the granted FIFO only when the output register takes its entry.
    always_comb begin
        chPop = '0;
        if (loadSlot && grantValid) begin
            chPop[grantCh] = 1'b1;
        end
    end

    assign nextPtr = (grantCh == CH_W'(NUM_CH - 1)) ? '0 : grantCh + 1'b1;

    // Output register: reload whenever it is empty or being accepted, hold
    // everything steady while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outCh_q    <= '0;
            outData_q  <= '0;
            outFerr_q  <= 1'b0;
            outPerr_q  <= 1'b0;
            rrPtr_q    <= '0;
        end else if (loadSlot) begin
            if (grantValid) begin
                outValid_q <= 1'b1;
                outCh_q    <= grantCh;
                outData_q  <= grantEntry.data;
                outFerr_q  <= grantEntry.ferr;
                outPerr_q  <= grantEntry.perr;
                rrPtr_q    <= nextPtr;
            end else begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_ch    = outCh_q;
    assign out_data  = outData_q;
    assign out_ferr  = outFerr_q;
    assign out_perr  = outPerr_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Testbench for uart_rx_monitor: a single-channel no-parity instance and a
// three-channel even-parity instance, driven with directed and random frames
// and checked against per-channel queues of expected bytes.

module tb_uart_rx_monitor;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } expT;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] rxA;
    logic [2:0] rxB;
    logic       readyA;
    logic       readyB;

    logic       aValid;
    logic [0:0] aCh;
    logic [7:0] aData;
    logic       aFerr;
    logic       aPerr;
    logic [0:0] ovfA;

    logic       bValid;
    logic [1:0] bCh;
    logic [7:0] bData;
    logic       bFerr;
    logic       bPerr;
    logic [2:0] ovfB;

    expT qA[$];
    expT qB[$];
    int  logCh[$];
    int  logCyc[$];
    int  checks    = 0;
    int  fails     = 0;
    int  cyc       = 0;
    bit  logOn     = 1'b0;
    bit  randReady = 1'b0;
    bit  expOvfA   = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_monitor #(
        .NUM_CH(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY(0)
    ) dutA (
        .clk(clk), .rst(rst), .rx(rxA),
        .out_valid(aValid), .out_ready(readyA), .out_ch(aCh),
        .out_data(aData), .out_ferr(aFerr), .out_perr(aPerr), .ovf(ovfA)
    );

    uart_rx_monitor #(
        .NUM_CH(3), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY(1)
    ) dutB (
        .clk(clk), .rst(rst), .rx(rxB),
        .out_valid(bValid), .out_ready(readyB), .out_ch(bCh),
        .out_data(bData), .out_ferr(bFerr), .out_perr(bPerr), .ovf(ovfB)
    );

    // Count every comparison and report mismatches on a single line.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serial frame as bit times, LSB first: start, data, optional parity, stop, idle.
    function automatic logic [12:0] buildFrame(input logic [7:0] d, input bit withPar,
                                               input bit parFlip, input bit stopLow);
        logic [12:0] f;
        int k;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        k = 9;
        if (withPar) begin
            f[k] = (^d) ^ parFlip;
            k++;
        end
        f[k] = ~stopLow;
        return f;
    endfunction

    // Send one frame on instance A (channel 0) or on the masked channels of B
    // simultaneously, recording the bytes the design should later deliver.
    task automatic applyStimulus(input bit toB, input logic [2:0] mask,
                                 input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [2:0] parFlip,
                                 input logic [2:0] stopLow);
        logic [12:0] fr [3];
        logic [7:0]  dv [3];
        expT e;
        dv[0] = d0;
        dv[1] = d1;
        dv[2] = d2;
        for (int c = 0; c < 3; c++) begin
            fr[c] = mask[c] ? buildFrame(dv[c], toB, parFlip[c], stopLow[c]) : 13'h1fff;
        end
        if (!toB) begin
            if (mask[0]) begin
                if (qA.size() >= DEPTH + 1) begin
                    expOvfA = 1'b1;
                end else begin
                    e.ch = 0; e.data = d0; e.ferr = stopLow[0]; e.perr = 1'b0;
                    qA.push_back(e);
                end
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (mask[c]) begin
                    e.ch = c; e.data = dv[c]; e.ferr = stopLow[c]; e.perr = parFlip[c];
                    qB.push_back(e);
                end
            end
        end
        for (int b = 0; b < 13; b++) begin
            if (!toB) begin
                rxA[0] = fr[0][b];
            end else begin
                for (int c = 0; c < 3; c++) rxB[c] = fr[c][b];
            end
            tick(CPB);
        end
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while ((qA.size() != 0 || qB.size() != 0) && n < 400) begin
            tick(1);
            n++;
        end
        tick(2);
        checkOutput(tag, 32'(qA.size() + qB.size()), 32'd0);
    endtask

    // Consumer side: every accepted byte must be the oldest outstanding one
    // of its channel.
    always @(negedge clk) begin
        expT e;
        int  hit;
        if (!rst) begin
            if (aValid && readyA) begin
                if (qA.size() == 0) begin
                    checkOutput("A_spurious", 32'(aValid), 32'd0);
                end else begin
                    e = qA.pop_front();
                    checkOutput("A_ch", 32'(aCh), 32'd0);
                    checkOutput("A_data", 32'(aData), 32'(e.data));
                    checkOutput("A_ferr", 32'(aFerr), 32'(e.ferr));
                    checkOutput("A_perr", 32'(aPerr), 32'(e.perr));
                end
            end
            if (bValid && readyB) begin
                hit = -1;
                for (int i = 0; i < qB.size(); i++) begin
                    if (hit < 0 && qB[i].ch == int'(bCh)) hit = i;
                end
                if (logOn) begin
                    logCh.push_back(int'(bCh));
                    logCyc.push_back(cyc);
                end
                if (hit < 0) begin
                    checkOutput("B_spurious", 32'(bCh), 32'hff);
                end else begin
                    e = qB[hit];
                    qB.delete(hit);
                    checkOutput("B_data", 32'(bData), 32'(e.data));
                    checkOutput("B_ferr", 32'(bFerr), 32'(e.ferr));
                    checkOutput("B_perr", 32'(bPerr), 32'(e.perr));
                end
            end
        end
    end

    // Random consumer back-pressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) begin
                readyA = 1'($urandom);
                readyB = 1'($urandom);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        rxA    = 1'b1;
        rxB    = 3'b111;
        readyA = 1'b1;
        readyB = 1'b1;
        tick(3);
        checkOutput("rst_A_valid", 32'(aValid), 32'd0);
        checkOutput("rst_A_ch", 32'(aCh), 32'd0);
        checkOutput("rst_A_data", 32'(aData), 32'd0);
        checkOutput("rst_A_ferr", 32'(aFerr), 32'd0);
        checkOutput("rst_A_perr", 32'(aPerr), 32'd0);
        checkOutput("rst_A_ovf", 32'(ovfA), 32'd0);
        checkOutput("rst_B_valid", 32'(bValid), 32'd0);
        checkOutput("rst_B_ch", 32'(bCh), 32'd0);
        checkOutput("rst_B_data", 32'(bData), 32'd0);
        checkOutput("rst_B_ovf", 32'(ovfB), 32'd0);
        rst = 1'b0;
        tick(2);

        // Three channels finishing together come out as 0,1,2 back to back.
        logOn = 1'b1;
        applyStimulus(1'b1, 3'b111, 8'h11, 8'h22, 8'h33, 3'b000, 3'b000);
        waitDrain("B_simul_drain");
        logOn = 1'b0;
        checkOutput("B_rr_count", 32'(logCh.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("B_rr_order", (i < logCh.size()) ? 32'(logCh[i]) : 32'hffff, 32'(i));
        end
        checkOutput("B_rr_b2b", (logCyc.size() == 3) ? 32'(logCyc[2] - logCyc[0]) : 32'hffff, 32'd2);

        applyStimulus(1'b0, 3'b001, 8'h55, 8'h00, 8'h00, 3'b000, 3'b000);
        applyStimulus(1'b0, 3'b001, 8'hA3, 8'h00, 8'h00, 3'b000, 3'b000);
        waitDrain("A_basic_drain");

        applyStimulus(1'b1, 3'b001, 8'h07, 8'h00, 8'h00, 3'b000, 3'b000);
        applyStimulus(1'b1, 3'b001, 8'h07, 8'h00, 8'h00, 3'b001, 3'b000);
        waitDrain("B_parity_drain");

        applyStimulus(1'b0, 3'b001, 8'h3C, 8'h00, 8'h00, 3'b000, 3'b001);
        waitDrain("A_ferr_drain");

        // A short low glitch must be rejected as a false start.
        rxA = 1'b0;
        tick(2);
        rxA = 1'b1;
        tick(4 * CPB);
        checkOutput("A_glitch_valid", 32'(aValid), 32'd0);

        randReady = 1'b1;
        for (int it = 0; it < 10; it++) begin
            applyStimulus(1'b0, 3'b001, 8'($urandom), 8'h00, 8'h00, 3'b000,
                          {2'b00, 1'($urandom_range(0, 3) == 0)});
            applyStimulus(1'b1, 3'($urandom_range(1, 7)), 8'($urandom), 8'($urandom),
                          8'($urandom), 3'($urandom), 3'($urandom) & 3'($urandom));
        end
        randReady = 1'b0;
        tick(1);
        readyA = 1'b1;
        readyB = 1'b1;
        waitDrain("rand_drain");

        // Stalled consumer: output register plus FIFO hold five, the sixth drops.
        readyA = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 3'b001, 8'($urandom), 8'h00, 8'h00, 3'b000, 3'b000);
        end
        tick(20);
        checkOutput("A_ovf_set", 32'(ovfA), 32'(expOvfA));
        checkOutput("A_ovf_expected", 32'(expOvfA), 32'd1);
        checkOutput("A_stall_valid", 32'(aValid), 32'd1);
        readyA = 1'b1;
        waitDrain("A_ovf_drain");
        checkOutput("A_ovf_sticky", 32'(ovfA), 32'd1);
        checkOutput("B_ovf_clear", 32'(ovfB), 32'd0);

        // Reset in the middle of a frame discards it and clears overflow.
        rxA = 1'b0;
        tick(3 * CPB);
        rst = 1'b1;
        qA.delete();
        qB.delete();
        expOvfA = 1'b0;
        tick(2);
        checkOutput("midrst_A_valid", 32'(aValid), 32'd0);
        checkOutput("midrst_A_ovf", 32'(ovfA), 32'd0);
        rxA = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        applyStimulus(1'b0, 3'b001, 8'h9E, 8'h00, 8'h00, 3'b000, 3'b000);
        waitDrain("A_after_rst_drain");
        checkOutput("A_after_rst_idle", 32'(aValid), 32'd0);
        checkOutput("A_after_rst_ovf", 32'(ovfA), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
